branch_pred_ctrl: RTL and testbench

Direction predictor and branch-resolution controller for the pipelined RV32I core. It holds a table of 2-bit saturating counters indexed by PC and supplies a taken/not-taken prediction to the ID stage, where the branch target is computed. It takes the EX-stage comparator result (`br_en`) for each conditional branch, detects mispredictions, and drives the redirect/flush request to the fetch unit. After reset, a small init FSM clears the table one entry per cycle.

---
 rtl/branch_pred_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl
//   Direction predictor and branch-resolution controller for the RV32I pipe.
//   A table of 2^IDX_BITS two-bit saturating counters, indexed by
//   pc[IDX_BITS+1:2], supplies a taken/not-taken prediction to ID.
//   Conditional branches that resolve in EX are checked against the
//   prediction they carried.
//   * On a mispredict, the block requests a redirect and a flush.
//   * In RUN, each resolve trains the indexed counter.
//   After reset, an init FSM clears the table to weakly not-taken, one entry
//   per cycle. While it runs, every prediction is not-taken.
//
// Ports
//   clk, rst_n        clock and synchronous active-low reset
//   id_pc             ID-stage lookup address
//   id_pred_taken     predicted direction for id_pc (combinational)
//   ex_valid          EX holds a valid instruction
//   ex_stall          EX is stalled; the instruction repeats next cycle
//   ex_is_br          EX instruction is a conditional branch
//   ex_pc             EX instruction PC
//   ex_pred_taken     prediction that travelled with the EX instruction
//   ex_br_en          comparator outcome for the EX branch
//   ex_target         pc + B-immediate
//   redirect_valid    mispredict: fetch loads redirect_pc, IF/ID flush
//   redirect_pc       correct next PC (zero when no redirect)
//   init_busy         table clear in progress
//
// Optional feature (macro BRANCH_PERF_CNT_EN)
//   perf_br_cnt       resolve events since reset (wraps at 2^32)
//   perf_mispred_cnt  mispredicts since reset (wraps at 2^32)

module branch_pred_ctrl #(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_pc,
  output logic        id_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        init_busy
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mispred_cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
  logic [1:0]          table_q [DEPTH];
  logic [1:0]          table_d [DEPTH];

  logic [IDX_BITS-1:0] id_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                resolve;
  logic                mispredict;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_nxt;
  logic                unused_id_pc_bits;

  assign id_idx = id_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign unused_id_pc_bits = ^{id_pc[31:IDX_BITS+2], id_pc[1:0]};

  // Resolve and mispredict detection. These are combinational from EX.
  // They are gated by rst_n, so a reset cycle never shows a redirect.
  always_comb begin
    resolve    = rst_n & ex_valid & ex_is_br & ~ex_stall;
    mispredict = resolve & (ex_pred_taken != ex_br_en);
  end

  // Saturating counter step for the EX branch index.
  always_comb begin
    ctr_cur = table_q[ex_idx];
    ctr_nxt = ctr_cur;
    if (ex_br_en) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  // Table write port. INIT owns the port while it runs. Otherwise, a
  // resolve event trains the counter.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      table_d[i] = table_q[i];
    end
    if (state_q == ST_INIT) begin
      table_d[init_idx_q] = 2'b01;
    end else if (resolve) begin
      table_d[ex_idx] = ctr_nxt;
    end
  end

  // The table is left unreset. Its contents are meaningless until INIT
  // has swept every entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      table_q[i] <= table_d[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // FSM: next state. The edge that writes the last entry also enters RUN.
  // As a result, INIT spans exactly DEPTH cycles.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + IDX_ONE;
        if (init_idx_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
    endcase
  end

  // FSM: outputs. Reset is folded in combinationally, so the reset cycle
  // itself shows reset values.
  always_comb begin
    init_busy      = ~rst_n | (state_q == ST_INIT);
    id_pred_taken  = init_busy ? 1'b0 : table_q[id_idx][1];
    redirect_valid = mispredict;
    redirect_pc    = '0;
    if (mispredict) begin
      redirect_pc = ex_br_en ? ex_target : (ex_pc + 32'd4);
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_br_cnt_q, perf_br_cnt_d;
  logic [31:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

  always_comb begin
    perf_br_cnt_d      = perf_br_cnt_q + (resolve ? 32'd1 : 32'd0);
    perf_mispred_cnt_d = perf_mispred_cnt_q + (mispredict ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_br_cnt_q      <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      perf_br_cnt_q      <= perf_br_cnt_d;
      perf_mispred_cnt_q <= perf_mispred_cnt_d;
    end
  end

  assign perf_br_cnt      = perf_br_cnt_q;
  assign perf_mispred_cnt = perf_mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;

  localparam int unsigned IDX_BITS = 6;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        ex_valid, ex_stall, ex_is_br, ex_pred_taken, ex_br_en;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        init_busy;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_br_cnt, perf_mispred_cnt;
`endif

  always #5 clk = ~clk;

  branch_pred_ctrl #(.IDX_BITS(IDX_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_is_br      (ex_is_br),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_br_en      (ex_br_en),
    .ex_target     (ex_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .init_busy     (init_busy)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_br_cnt     (perf_br_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  typedef struct {
    logic        busy;
    logic        pred;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counters held as plain integers in the range 0..3.
  int          ctr[DEPTH];
  int          init_left = DEPTH;
  logic [31:0] m_bc = 0, m_mc = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: combinational outputs are sampled mid-cycle and compared
  // against the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("init_busy", {31'd0, init_busy}, {31'd0, e.busy});
      chk("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, e.pred});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
      if (e.busy && !e.rv) chk("redirect_pc_idle", redirect_pc, 32'd0);
`ifdef BRANCH_PERF_CNT_EN
      chk("perf_br_cnt", perf_br_cnt, e.bc);
      chk("perf_mispred_cnt", perf_mispred_cnt, e.mc);
`endif
    end
  end

  // Drives one cycle, pushes the expectation, then advances the model at the edge.
  task automatic step(input bit rst, input bit v, input bit st, input bit br,
                      input logic [31:0] pc, input bit pt, input bit be,
                      input logic [31:0] tg, input logic [31:0] ipc);
    exp_t e;
    bit   busy, ev, mis;
    rst_n = rst; ex_valid = v; ex_stall = st; ex_is_br = br; ex_pc = pc;
    ex_pred_taken = pt; ex_br_en = be; ex_target = tg; id_pc = ipc;
    busy   = !rst || (init_left > 0);
    ev     = rst && v && br && !st;
    mis    = ev && (pt != be);
    e.busy = busy;
    e.pred = busy ? 1'b0 : (ctr[idx_of(ipc)] >= 2);
    e.rv   = mis;
    e.rpc  = mis ? (be ? tg : pc + 32'd4) : 32'd0;
    e.bc   = m_bc;
    e.mc   = m_mc;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      init_left = DEPTH; m_bc = 0; m_mc = 0;
    end else begin
      if (ev) m_bc = m_bc + 1;
      if (mis) m_mc = m_mc + 1;
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) foreach (ctr[i]) ctr[i] = 1;
      end else if (ev) begin
        if (be) ctr[idx_of(pc)] = (ctr[idx_of(pc)] < 3) ? ctr[idx_of(pc)] + 1 : 3;
        else    ctr[idx_of(pc)] = (ctr[idx_of(pc)] > 0) ? ctr[idx_of(pc)] - 1 : 0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, ipc);
  endtask

  task automatic brn(input logic [31:0] pc, input bit pt, input bit be,
                     input logic [31:0] tg, input logic [31:0] ipc, input bit st);
    step(1, 1, st, 1, pc, pt, be, tg, ipc);
  endtask

  task automatic do_reset();
    step(0, 1, 0, 1, 32'h100, 0, 1, 32'h140, 32'h100);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h104;
      3: return 32'h108;
      4: return 32'h300;
      default: return {$urandom} & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1, $urandom_range(0, 1), 0, $urandom_range(0, 1), pick_pc(),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom, pick_pc());
      else
        step(1, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) != 0, pick_pc(), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom, pick_pc());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (ctr[i]) ctr[i] = 0;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 66; i++) idle($urandom & 32'hFFFF_FFFC);
    // Taken twice at 0x100: 01 -> 10 -> 11
    brn(32'h100, 0, 1, 32'h140, 32'h100, 0);
    brn(32'h100, 0, 1, 32'h140, 32'h100, 0);
    idle(32'h100);
    // Not-taken from 11: 10, 01, then saturate at 00
    for (int i = 0; i < 5; i++) brn(32'h100, 1, 0, 32'h140, 32'h100, 0);
    idle(32'h100);
    // Stalled mispredicting branch: one event on release
    for (int i = 0; i < 3; i++) brn(32'h100, 0, 1, 32'h180, 32'h100, 1);
    brn(32'h100, 0, 1, 32'h180, 32'h100, 0);
    idle(32'h100);
    // Aliasing 0x100/0x200 plus a same-cycle lookup during the update
    brn(32'h200, 0, 1, 32'h240, 32'h100, 0);
    brn(32'h200, 0, 1, 32'h240, 32'h100, 0);
    brn(32'h200, 1, 1, 32'h240, 32'h100, 0);
    idle(32'h100);
    // Wrap case for pc+4
    brn(32'hFFFF_FFFC, 1, 0, 32'h0, 32'h0, 0);
    rand_cycles(1500);
    // Reset mid-INIT at idx 30, with a branch in EX
    do_reset();
    for (int i = 0; i < 30; i++) idle(pick_pc());
    do_reset();
    for (int i = 0; i < 66; i++) brn(pick_pc(), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, pick_pc(), 0);
    rand_cycles(500);
    idle(32'h0);
    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
